// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a 64-bit synchronous on-chip RAM. Independent read and
// write FSMs, one outstanding burst each; out-of-map bursts answer SLVERR.
module axi_ram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int          DEPTH_LOG2 = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  s_axi_awid,
  input  logic [31:0] s_axi_awaddr,
  input  logic [3:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [5:0]  s_axi_wid,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [5:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [5:0]  s_axi_arid,
  input  logic [31:0] s_axi_araddr,
  input  logic [3:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [5:0]  s_axi_rid,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef logic [DEPTH_LOG2-1:0] word_t;

  function automatic logic burst_ok(input logic [31:0] addr, input logic [3:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (addr[2:0] == 3'b000) &&
           (({1'b0, off >> 3} + 33'(len)) < (33'd1 << DEPTH_LOG2)) &&
           (size == 3'b011) && (burst == 2'b01);
  endfunction

  function automatic word_t word_of(input logic [31:0] addr);
    return word_t'((addr - BASE_ADDR) >> 3);
  endfunction

  logic unused_wid;
  assign unused_wid = ^s_axi_wid;

  // Holds both ready outputs low until the first edge after reset releases.
  logic out_of_rst_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_of_rst_q <= 1'b0;
    else     out_of_rst_q <= 1'b1;
  end

  // ---------------- read path ----------------
  rstate_e    rstate_q, rstate_d;
  logic [5:0] rid_q;
  word_t      rword_q, rd_addr;
  logic [3:0] rlen_q, rbeat_q;
  logic       rerr_q, rd_en, ar_hs, r_hs;
  logic [63:0] ram_rd_q;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rstate_q <= R_IDLE;
    else     rstate_q <= rstate_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_FETCH;
      R_FETCH: rstate_d = R_DATA;
      R_DATA:  if (r_hs && s_axi_rlast) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = rword_q;
    unique case (rstate_q)
      R_IDLE:  s_axi_arready = out_of_rst_q;
      R_FETCH: rd_en = 1'b1;
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = (rbeat_q == rlen_q);
        // Prefetch the next word on a handshake so beats stream back to back.
        if (s_axi_rready && !s_axi_rlast) begin
          rd_en   = 1'b1;
          rd_addr = rword_q + word_t'(1);
        end
      end
      default: ;
    endcase
  end

  assign s_axi_rid   = s_axi_rvalid ? rid_q : 6'd0;
  assign s_axi_rdata = (s_axi_rvalid && !rerr_q) ? ram_rd_q : 64'd0;
  assign s_axi_rresp = (s_axi_rvalid && rerr_q) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rid_q   <= '0;
      rword_q <= '0;
      rlen_q  <= '0;
      rbeat_q <= '0;
      rerr_q  <= 1'b0;
    end else if (ar_hs) begin
      rid_q   <= s_axi_arid;
      rword_q <= word_of(s_axi_araddr);
      rlen_q  <= s_axi_arlen;
      rbeat_q <= '0;
      rerr_q  <= !burst_ok(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
    end else if (r_hs && !s_axi_rlast) begin
      rword_q <= rword_q + word_t'(1);
      rbeat_q <= rbeat_q + 4'd1;
    end
  end

  // ---------------- write path ----------------
  wstate_e    wstate_q, wstate_d;
  logic [5:0] wid_q;
  word_t      wword_q;
  logic [3:0] wlen_q, wbeat_q;
  logic       werr_q, wbad_q, wr_en, w_final, aw_hs, w_hs;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign w_final = (wbeat_q == wlen_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wstate_q <= W_IDLE;
    else     wstate_q <= wstate_d;
  end

  always_comb begin
    wstate_d = wstate_q;
    unique case (wstate_q)
      W_IDLE:  if (aw_hs) wstate_d = W_DATA;
      W_DATA:  if (w_hs && (w_final || s_axi_wlast)) wstate_d = W_RESP;
      W_RESP:  if (s_axi_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bid     = 6'd0;
    s_axi_bresp   = RESP_OKAY;
    wr_en         = 1'b0;
    unique case (wstate_q)
      W_IDLE: s_axi_awready = out_of_rst_q;
      W_DATA: begin
        s_axi_wready = 1'b1;
        wr_en        = s_axi_wvalid && !werr_q;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = wid_q;
        s_axi_bresp  = wbad_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wid_q   <= '0;
      wword_q <= '0;
      wlen_q  <= '0;
      wbeat_q <= '0;
      werr_q  <= 1'b0;
      wbad_q  <= 1'b0;
    end else if (aw_hs) begin
      wid_q   <= s_axi_awid;
      wword_q <= word_of(s_axi_awaddr);
      wlen_q  <= s_axi_awlen;
      wbeat_q <= '0;
      werr_q  <= !burst_ok(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
      wbad_q  <= !burst_ok(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
    end else if (w_hs) begin
      if (s_axi_wlast != w_final) wbad_q <= 1'b1;
      if (!(s_axi_wlast || w_final)) begin
        wword_q <= wword_q + word_t'(1);
        wbeat_q <= wbeat_q + 4'd1;
      end
    end
  end

  // ---------------- RAM ----------------
  logic [63:0] mem [2**DEPTH_LOG2];

  // NOTE: the array and its read register carry no reset so they map onto
  // block RAM; a same-cycle read of a word being written returns the old data.
  always_ff @(posedge clk) begin
    if (rd_en) ram_rd_q <= mem[rd_addr];
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (s_axi_wstrb[i]) mem[wword_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Self-checking bench for axi_ram_slave: a vector table of AXI bursts driven
// against a reference memory, plus hand-written reset and protocol sequences.
module tb_axi_ram_slave;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [1:0]  OKAY = 2'b00;
  localparam logic [1:0]  SERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [3:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [5:0]  s_axi_wid;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [5:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [5:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [3:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid, s_axi_arready;
  logic [5:0]  s_axi_rid;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi_ram_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wid(s_axi_wid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference memory, keyed by RAM word index.
  logic [63:0] ref_mem [int];

  function automatic logic [63:0] model_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 64'd0;
  endfunction

  function automatic int word_idx(input logic [31:0] addr);
    return int'((addr - BASE) >> 3);
  endfunction

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [5:0]  id;
  } rbeat_t;

  rbeat_t rq[$];

  typedef struct {
    logic        is_rd;
    logic [5:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  strb;
    logic [63:0] data;
    logic        rand_rdy;
    logic [1:0]  exp_resp;
    logic        chk_w0;
    logic [63:0] w0;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic is_rd, input logic [5:0] id, input logic [31:0] addr,
                                  input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                                  input logic [7:0] strb, input logic [63:0] data, input logic rand_rdy,
                                  input logic [1:0] exp_resp, input logic chk_w0, input logic [63:0] w0);
    vec_t v;
    v.is_rd = is_rd; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.strb = strb; v.data = data; v.rand_rdy = rand_rdy; v.exp_resp = exp_resp;
    v.chk_w0 = chk_w0; v.w0 = w0;
    vecs.push_back(v);
  endfunction

  task automatic b_phase(input logic [5:0] id, input logic [1:0] exp_resp);
    logic hs = 1'b0;
    int   n  = 0;
    s_axi_bready = 1'b1;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = s_axi_bvalid;
      if (hs) begin
        check("bresp", 64'(s_axi_bresp), 64'(exp_resp));
        check("bid", 64'(s_axi_bid), 64'(id));
      end
      @(posedge clk); #1;
      n++;
    end
    s_axi_bready = 1'b0;
    check("b_handshake", 64'(hs), 64'd1);
  endtask

  // Beat k carries data+k; wlast is driven on beat last_at.
  task automatic axi_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                           input logic [63:0] data, input int last_at, input logic [1:0] exp_resp,
                           input logic upd_model);
    logic hs;
    int   n;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = s_axi_awready; @(posedge clk); #1; n++;
    end
    s_axi_awvalid = 1'b0;
    check("aw_handshake", 64'(hs), 64'd1);
    for (int k = 0; k <= last_at; k++) begin
      s_axi_wdata = data + 64'(k); s_axi_wstrb = strb;
      s_axi_wlast = (k == last_at); s_axi_wvalid = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < 100) begin
        @(negedge clk); hs = s_axi_wready; @(posedge clk); #1; n++;
      end
      check("w_handshake", 64'(hs), 64'd1);
      if (upd_model) begin
        logic [63:0] m;
        m = model_rd(word_idx(addr) + k);
        for (int b = 0; b < 8; b++) if (strb[b]) m[8*b +: 8] = s_axi_wdata[8*b +: 8];
        ref_mem[word_idx(addr) + k] = m;
      end
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    b_phase(id, exp_resp);
  endtask

  task automatic axi_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp,
                          input logic rand_rdy, input logic chk_w0, input logic [63:0] w0);
    logic   hs;
    int     n, t_ar, first_c, last_c;
    rbeat_t e;
    for (int k = 0; k <= int'(len); k++) begin
      e.data = (exp_resp == OKAY) ? model_rd(word_idx(addr) + k) : 64'd0;
      if (k == 0 && chk_w0) e.data = w0;
      e.resp = exp_resp; e.last = (k == int'(len)); e.id = id;
      rq.push_back(e);
    end
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = s_axi_arready; @(posedge clk); #1; n++;
    end
    s_axi_arvalid = 1'b0;
    t_ar = cyc;
    check("ar_handshake", 64'(hs), 64'd1);
    first_c = -1; last_c = -1; n = 0;
    while (rq.size() > 0 && n < 300) begin
      s_axi_rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (s_axi_rvalid) begin
        e = rq[0];
        // Stalled beats are compared too, so any drift while held shows up.
        check("rdata", s_axi_rdata, e.data);
        check("rresp", 64'(s_axi_rresp), 64'(e.resp));
        check("rlast", 64'(s_axi_rlast), 64'(e.last));
        check("rid", 64'(s_axi_rid), 64'(e.id));
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (s_axi_rready) void'(rq.pop_front());
      end
      @(posedge clk); #1;
      n++;
    end
    s_axi_rready = 1'b0;
    check("r_beats_left", 64'(rq.size()), 64'd0);
    rq.delete();
    if (!rand_rdy) begin
      // First beat visible in the cycle after edge T+1, i.e. sampled at edge T+2.
      check("r_latency", 64'(first_c - t_ar), 64'd1);
      check("r_stream", 64'(last_c - first_c), 64'(len));
    end
    @(negedge clk);
    check("r_idle_arready", 64'(s_axi_arready), 64'd1);
    check("r_idle_rvalid", 64'(s_axi_rvalid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic hs;
    int   n, got;

    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wid = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    //       rd  id     addr          len   size  bst   strb   data                    rnd  resp  w0?  w0
    add_vec(0, 6'd5,  32'h2000_0000, 4'd0,  3'd3, 2'd1, 8'hFF, 64'h1122334455667788,  0, OKAY, 0, 64'd0);
    add_vec(1, 6'd3,  32'h2000_0000, 4'd0,  3'd3, 2'd1, 8'h00, 64'd0,                 0, OKAY, 1, 64'h1122334455667788);
    add_vec(0, 6'd1,  32'h2000_0100, 4'd15, 3'd3, 2'd1, 8'hFF, 64'h0000000000000100,  0, OKAY, 0, 64'd0);
    add_vec(1, 6'd2,  32'h2000_0100, 4'd15, 3'd3, 2'd1, 8'h00, 64'd0,                 1, OKAY, 1, 64'h100);
    add_vec(1, 6'd2,  32'h2000_0100, 4'd15, 3'd3, 2'd1, 8'h00, 64'd0,                 0, OKAY, 0, 64'd0);
    add_vec(0, 6'd7,  32'h2000_0200, 4'd0,  3'd3, 2'd1, 8'hFF, 64'hFFFFFFFFFFFFFFFF,  0, OKAY, 0, 64'd0);
    add_vec(0, 6'd7,  32'h2000_0200, 4'd0,  3'd3, 2'd1, 8'h0F, 64'h0,                 0, OKAY, 0, 64'd0);
    add_vec(1, 6'd9,  32'h2000_0200, 4'd0,  3'd3, 2'd1, 8'h00, 64'd0,                 0, OKAY, 1, 64'hFFFFFFFF00000000);
    add_vec(1, 6'd4,  32'h1FFF_FFF8, 4'd3,  3'd3, 2'd1, 8'h00, 64'd0,                 0, SERR, 0, 64'd0);
    add_vec(0, 6'd6,  32'h2000_0000, 4'd0,  3'd3, 2'd2, 8'hFF, 64'hDEADBEEFDEADBEEF,  0, SERR, 0, 64'd0);
    add_vec(1, 6'd4,  32'h2000_0000, 4'd0,  3'd3, 2'd1, 8'h00, 64'd0,                 0, OKAY, 1, 64'h1122334455667788);
    add_vec(0, 6'd8,  32'h2001_FFF0, 4'd3,  3'd3, 2'd1, 8'hFF, 64'h5555AAAA5555AAAA,  0, SERR, 0, 64'd0);
    add_vec(1, 6'd8,  32'h2001_FFF0, 4'd3,  3'd3, 2'd1, 8'h00, 64'd0,                 0, SERR, 0, 64'd0);
    add_vec(0, 6'd10, 32'h2001_FFF8, 4'd0,  3'd3, 2'd1, 8'hFF, 64'hA5A5A5A50F0F0F0F,  0, OKAY, 0, 64'd0);
    add_vec(1, 6'd10, 32'h2001_FFF8, 4'd0,  3'd3, 2'd1, 8'h00, 64'd0,                 0, OKAY, 1, 64'hA5A5A5A50F0F0F0F);
    add_vec(1, 6'd11, 32'h2000_0004, 4'd0,  3'd3, 2'd1, 8'h00, 64'd0,                 0, SERR, 0, 64'd0);
    add_vec(1, 6'd12, 32'h2000_0000, 4'd0,  3'd2, 2'd1, 8'h00, 64'd0,                 0, SERR, 0, 64'd0);
    add_vec(0, 6'd13, 32'h2000_0000, 4'd1,  3'd2, 2'd1, 8'hFF, 64'h0BADF00D0BADF00D,  0, SERR, 0, 64'd0);
    add_vec(1, 6'd13, 32'h2000_0000, 4'd0,  3'd3, 2'd1, 8'h00, 64'd0,                 0, OKAY, 1, 64'h1122334455667788);

    // Reset state and ready release timing.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 64'(s_axi_arready), 64'd0);
    check("rst_awready", 64'(s_axi_awready), 64'd0);
    check("rst_wready", 64'(s_axi_wready), 64'd0);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_rdata", s_axi_rdata, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rel_arready_low", 64'(s_axi_arready), 64'd0);
    check("rel_awready_low", 64'(s_axi_awready), 64'd0);
    @(negedge clk);
    check("rel_arready_high", 64'(s_axi_arready), 64'd1);
    check("rel_awready_high", 64'(s_axi_awready), 64'd1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].is_rd)
        axi_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                 vecs[i].exp_resp, vecs[i].rand_rdy, vecs[i].chk_w0, vecs[i].w0);
      else
        axi_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                  vecs[i].strb, vecs[i].data, int'(vecs[i].len), vecs[i].exp_resp,
                  vecs[i].exp_resp == OKAY);
    end

    // W beats offered three cycles ahead of AW must stall until after AW.
    s_axi_wdata = 64'hCAFEF00D12345678; s_axi_wstrb = 8'hFF;
    s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    repeat (3) begin
      @(negedge clk); check("early_w_wready", 64'(s_axi_wready), 64'd0);
      @(posedge clk); #1;
    end
    s_axi_awid = 6'd21; s_axi_awaddr = 32'h2000_0300; s_axi_awlen = 4'd0;
    s_axi_awsize = 3'd3; s_axi_awburst = 2'd1; s_axi_awvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = s_axi_awready;
      check("early_w_wready_aw", 64'(s_axi_wready), 64'd0);
      @(posedge clk); #1; n++;
    end
    s_axi_awvalid = 1'b0;
    check("early_aw_handshake", 64'(hs), 64'd1);
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = s_axi_wready; @(posedge clk); #1; n++;
    end
    check("early_w_handshake", 64'(hs), 64'd1);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    ref_mem[word_idx(32'h2000_0300)] = 64'hCAFEF00D12345678;
    b_phase(6'd21, OKAY);
    axi_read(6'd22, 32'h2000_0300, 4'd0, 3'd3, 2'd1, OKAY, 1'b0, 1'b1, 64'hCAFEF00D12345678);

    // wlast on beat 2 of a 4-beat burst ends the burst with SLVERR.
    axi_write(6'd23, 32'h2000_0400, 4'd3, 3'd3, 2'd1, 8'hFF, 64'h77, 2, SERR, 1'b0);

    // Reset asserted while beat 4 of a 16-beat read is on the bus.
    s_axi_arid = 6'd24; s_axi_araddr = 32'h2000_0100; s_axi_arlen = 4'd15;
    s_axi_arsize = 3'd3; s_axi_arburst = 2'd1; s_axi_arvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = s_axi_arready; @(posedge clk); #1; n++;
    end
    s_axi_arvalid = 1'b0;
    check("rstseq_ar_handshake", 64'(hs), 64'd1);
    s_axi_rready = 1'b1; got = 0; n = 0;
    while (got < 4 && n < 50) begin
      @(negedge clk);
      if (s_axi_rvalid) begin
        check("rstseq_rdata", s_axi_rdata, model_rd(word_idx(32'h2000_0100) + got));
        got++;
      end
      @(posedge clk); #1; n++;
    end
    check("rstseq_beats", 64'(got), 64'd4);
    @(negedge clk);
    check("rstseq_beat4_valid", 64'(s_axi_rvalid), 64'd1);
    check("rstseq_beat4_data", s_axi_rdata, model_rd(word_idx(32'h2000_0100) + 4));
    rst = 1'b1;
    #1;
    check("rstseq_rvalid_drop", 64'(s_axi_rvalid), 64'd0);
    check("rstseq_rdata_zero", s_axi_rdata, 64'd0);
    check("rstseq_arready_low", 64'(s_axi_arready), 64'd0);
    repeat (2) begin
      @(negedge clk); check("rstseq_hold_rvalid", 64'(s_axi_rvalid), 64'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstseq_rel_arready_low", 64'(s_axi_arready), 64'd0);
    check("rstseq_rel_rvalid", 64'(s_axi_rvalid), 64'd0);
    @(negedge clk);
    check("rstseq_rel_arready_high", 64'(s_axi_arready), 64'd1);
    check("rstseq_no_beats", 64'(s_axi_rvalid), 64'd0);
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    axi_read(6'd25, 32'h2000_0000, 4'd0, 3'd3, 2'd1, OKAY, 1'b0, 1'b1, 64'h1122334455667788);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
